sobel_pixel_source: RTL and testbench
=====================================

# sobel_pixel_source

Streams a stored grayscale frame, in raster order, into the Sobel edge datapath's `data_in` port. It reads an external synchronous frame memory with one cycle of read latency and emits one 8-bit pixel per accepted handshake. Each pixel carries start-of-frame, end-of-line and end-of-frame flags so the downstream filter can track its row and column counters without free-running on `clk`. It sits between the image ROM/BRAM and the edge filter, and each `start` pulse produces exactly one frame.

## Interface
- `ADDR_W`, 20, frame-memory address width; addresses wrap modulo 2^ADDR_W.
- `PIX_W`, 8, pixel width.
- `clk`  in  1  single system clock; all logic on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to stream one frame; sampled only in IDLE.
- `width`  in  16  pixels per row; captured on accepted `start`.
- `height`  in  16  rows per frame; captured on accepted `start`.
- `base_addr`  in  ADDR_W  address of pixel (0,0); captured on accepted `start`.
- `mem_en`  out  1  read strobe to frame memory.
- `mem_addr`  out  ADDR_W  read address.
- `mem_data`  in  PIX_W  read data, valid the cycle after `mem_en`.
- `pix_data`  out  PIX_W  pixel to the edge filter.
- `pix_valid`  out  1  `pix_data` and flags are valid.
- `pix_ready`  in  1  consumer accepts; transfer = `pix_valid & pix_ready`.
- `pix_sof`, `pix_eol`, `pix_eof`  out  1 each  flags qualified by `pix_valid`.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last transfer.
- `err`  out  1  one-cycle pulse when `start` arrives with `width==0` or `height==0`.

## Operation
- FSM states:
  - IDLE: waits for `start`.
  - RUN: issuing reads.
  - DRAIN: all reads issued, buffered pixels still pending.
  - DONE: drives the `done` pulse and returns to IDLE.
- IDLE with `start` and nonzero dimensions: capture `width`, `height`, `base_addr`; go to RUN.
- IDLE with `start` and a zero dimension: pulse `err`, stay in IDLE, issue no reads.
- `start` outside IDLE is ignored.
- Read address:
  - Starts at `base_addr` and increments by 1 per issued read; no multiplier.
  - Total reads issued is exactly width*height.
- Column and row counters run with issued reads and tag each read with its flags:
  - `sof` when row=0, col=0.
  - `eol` when col=width-1.
  - `eof` when row=height-1 and col=width-1.
- The flags are pipelined alongside the memory latency and stored with the pixel.
- Output buffering:
  - Output register plus one skid entry; capacity 2.
  - `occ` is the number of entries held (0..2). `inflight` is 1 if a read was issued in the previous cycle.
  - A read is issued when reads remain and `occ + inflight - xfer < 2`. This never overflows and sustains 1 pixel/clk with `pix_ready` held high.
- RUN moves to DRAIN on the cycle the last read is issued.
- DRAIN moves to DONE on the transfer of the `eof` pixel. DONE moves to IDLE after one cycle.

## Timing
- Reset (`rstn` low, asynchronous) drives:
  - `mem_en`, `pix_valid`, the flags, `busy`, `done`, `err` to 0.
  - `mem_addr` and `pix_data` to 0.
  - FSM to IDLE; buffer and in-flight read discarded.
- Reset mid-frame aborts the frame. No `done` is produced, and the next `start` restarts from (0,0).
- Accepted `start` at edge E0:
  - `busy` and `mem_en` (at `base_addr`) are high after E0.
  - The first `pix_valid` is high after E2.
- With `pix_ready` held high: one transfer per cycle. The last transfer is at edge E(W*H+2), and `done` is high for the cycle after it.
- While `pix_valid & !pix_ready`, `pix_data` and the flags hold stable. `pix_valid` never drops without a transfer.
- `err` is high for the cycle after the offending `start` edge.
- Address wrap: `base_addr` + n overflows modulo 2^ADDR_W with no error.
- width=1: every pixel has `eol`=1. width=1, height=1: a single pixel with `sof`, `eol` and `eof` all 1.

## Test plan
- 3x2 frame, base 0x100, `pix_ready`=1: pixels from addresses 0x100..0x105 in order; `sof` on the 1st pixel, `eol` on the 3rd and 6th, `eof` on the 6th; first valid 2 cycles after `start`, `done` the cycle after the 6th transfer.
- Same frame, `pix_ready` toggled 1,0,0,1,…: no pixel lost or duplicated; data stable during stalls; at most 2 reads outstanding plus buffered.
- width=1, height=1: exactly one pixel with all flags 1, and one `done` pulse.
- `start` with width=0 (and again with height=5, width=0): `err` pulse, `mem_en` never asserted, `busy` stays 0.
- `start` pulsed again mid-frame: ignored, frame count unaffected. `rstn` low after 4 transfers of a 4x4 frame: all outputs 0 at once; the next `start` begins at `base_addr` with `sof`.
- base=2^20-2, 2x2 frame: addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.

Source files
------------

// File: rtl/sobel_pixel_source.sv
// Raster-order frame reader feeding the Sobel datapath: issues frame-memory reads,
// tags each pixel with sof/eol/eof and buffers it in an output register plus a skid slot.
module sobel_pixel_source #(
    parameter int ADDR_W = 20,
    parameter int PIX_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [15:0]       width,
    input  logic [15:0]       height,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_data,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [15:0]         width_q, width_d, height_q, height_d;
    logic [15:0]         col_q, col_d, row_q, row_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                inflight_q, inflight_d;
    logic [2:0]          tag_q, tag_d;
    logic [1:0]          occ_q, occ_d;
    logic [PIX_W-1:0]    out_data_q, out_data_d, skid_data_q, skid_data_d;
    logic [2:0]          out_flags_q, out_flags_d, skid_flags_q, skid_flags_d;
    logic                err_q, err_d;

    logic                issue, xfer, last_col, last_row;
    logic [2:0]          pending;

    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        height_d     = height_q;
        col_d        = col_q;
        row_d        = row_q;
        addr_d       = addr_q;
        tag_d        = tag_q;
        occ_d        = occ_q;
        out_data_d   = out_data_q;
        out_flags_d  = out_flags_q;
        skid_data_d  = skid_data_q;
        skid_flags_d = skid_flags_q;
        err_d        = 1'b0;
        issue        = 1'b0;

        xfer     = (occ_q != 2'd0) && pix_ready;
        last_col = (col_q == width_q - 16'd1);
        last_row = (row_q == height_q - 16'd1);
        // Entries committed once this edge settles: held + arriving - leaving.
        pending  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, xfer};

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (width == 16'd0 || height == 16'd0) begin
                        err_d = 1'b1;
                    end else begin
                        width_d  = width;
                        height_d = height;
                        addr_d   = base_addr;
                        col_d    = '0;
                        row_d    = '0;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                issue = (pending < 3'd2);
                if (issue) begin
                    addr_d = addr_q + 1'b1;
                    tag_d  = {(row_q == 16'd0) && (col_q == 16'd0), last_col, last_col && last_row};
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 16'd1;
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                    if (last_col && last_row) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer && out_flags_q[0]) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        inflight_d = issue;

        // Returning read data lands in the head register, or the skid slot if the head is held.
        case (occ_q)
            2'd0: begin
                if (inflight_q) begin
                    out_data_d  = mem_data;
                    out_flags_d = tag_q;
                    occ_d       = 2'd1;
                end
            end
            2'd1: begin
                if (xfer && inflight_q) begin
                    out_data_d  = mem_data;
                    out_flags_d = tag_q;
                end else if (xfer) begin
                    occ_d = 2'd0;
                end else if (inflight_q) begin
                    skid_data_d  = mem_data;
                    skid_flags_d = tag_q;
                    occ_d        = 2'd2;
                end
            end
            default: begin
                if (xfer) begin
                    out_data_d  = skid_data_q;
                    out_flags_d = skid_flags_q;
                    if (inflight_q) begin
                        skid_data_d  = mem_data;
                        skid_flags_d = tag_q;
                    end else begin
                        occ_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            width_q      <= '0;
            height_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            inflight_q   <= 1'b0;
            tag_q        <= '0;
            occ_q        <= '0;
            out_data_q   <= '0;
            out_flags_q  <= '0;
            skid_data_q  <= '0;
            skid_flags_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            col_q        <= col_d;
            row_q        <= row_d;
            addr_q       <= addr_d;
            inflight_q   <= inflight_d;
            tag_q        <= tag_d;
            occ_q        <= occ_d;
            out_data_q   <= out_data_d;
            out_flags_q  <= out_flags_d;
            skid_data_q  <= skid_data_d;
            skid_flags_q <= skid_flags_d;
            err_q        <= err_d;
        end
    end

    assign mem_en    = issue;
    assign mem_addr  = addr_q;
    assign pix_valid = (occ_q != 2'd0);
    assign pix_data  = out_data_q;
    assign pix_sof   = pix_valid && out_flags_q[2];
    assign pix_eol   = pix_valid && out_flags_q[1];
    assign pix_eof   = pix_valid && out_flags_q[0];
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_sobel_pixel_source.sv
// Self-checking bench for sobel_pixel_source: frames streamed from a modelled
// synchronous memory and compared against a raster-order reference model.
module tb_sobel_pixel_source;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] width = '0, height = '0;
    logic [19:0] base_addr = '0;
    logic        mem_en;
    logic [19:0] mem_addr;
    logic [7:0]  mem_data = '0;
    logic [7:0]  pix_data;
    logic        pix_valid, pix_ready = 1'b0;
    logic        pix_sof, pix_eol, pix_eof, busy, done, err;

    int nvec = 0;
    int nerr = 0;

    sobel_pixel_source #(.ADDR_W(20), .PIX_W(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .width(width), .height(height),
        .base_addr(base_addr), .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix_of(input logic [19:0] a);
        return (a[7:0] ^ a[15:8]) + {4'h0, a[19:16]} + 8'h11;
    endfunction

    // Frame memory: one cycle of read latency.
    always @(posedge clk) if (mem_en) mem_data <= pix_of(mem_addr);

    // mode 0: ready held high, 1: ready pattern 1,0,0,1..., 2: random ready
    task automatic test_frame(input int w, input int h, input logic [19:0] base,
                              input int mode, input bit restart_mid);
        int n = w * h;
        int budget = 20 * n + 40;
        int idx = 0, nrd = 0, ndone = 0, cyc = 1;
        int first_valid = -1, last_xfer = -1;
        bit stall_prev = 0;
        logic [10:0] held;
        logic [10:0] got, exp;
        logic [19:0] ea;
        int pat[4] = '{1, 0, 0, 1};
        @(negedge clk);
        width = 16'(w); height = 16'(h); base_addr = base; start = 1'b1;
        pix_ready = (mode != 2) ? 1'b1 : 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        while (ndone == 0 && cyc < budget) begin
            if (mode == 0) pix_ready = 1'b1;
            else if (mode == 1) pix_ready = 1'(pat[(cyc - 1) % 4]);
            else pix_ready = 1'($urandom_range(0, 1));
            start = (restart_mid && cyc == 5);
            #1;
            if (cyc == 1) begin
                nvec++;
                if ({busy, mem_en, mem_addr} !== {1'b1, 1'b1, base}) begin
                    nerr++;
                    $display("FAIL first_read got busy=%b en=%b addr=%h exp 1 1 %h", busy, mem_en, mem_addr, base);
                end
            end
            if (mem_en) begin
                ea = base + 20'(nrd);
                nrd++;
                nvec++;
                if (mem_addr !== ea || nrd > n) begin
                    nerr++;
                    $display("FAIL read_addr #%0d got %h exp %h (of %0d)", nrd, mem_addr, ea, n);
                end
            end
            nvec++;
            if (nrd - idx - ((pix_valid && pix_ready) ? 1 : 0) > 2) begin
                nerr++;
                $display("FAIL outstanding got %0d exp <=2", nrd - idx - ((pix_valid && pix_ready) ? 1 : 0));
            end
            if (stall_prev) begin
                nvec++;
                if ({pix_valid, pix_sof, pix_eol, pix_eof, pix_data} !== {1'b1, held}) begin
                    nerr++;
                    $display("FAIL stall_hold got %b_%h exp 1_%h", pix_valid, {pix_sof, pix_eol, pix_eof, pix_data}, held);
                end
            end
            if (pix_valid && first_valid < 0) begin
                first_valid = cyc;
                nvec++;
                if (first_valid != 3) begin
                    nerr++;
                    $display("FAIL first_valid got cycle %0d exp 3", first_valid);
                end
            end
            if (done) begin
                ndone++;
                nvec++;
                if (cyc != last_xfer + 1) begin
                    nerr++;
                    $display("FAIL done_time got cycle %0d exp %0d", cyc, last_xfer + 1);
                end
            end
            if (pix_valid && pix_ready) begin
                ea = base + 20'(idx);
                exp = {idx == 0, (idx % w) == w - 1, idx == n - 1, pix_of(ea)};
                got = {pix_sof, pix_eol, pix_eof, pix_data};
                nvec++;
                if (got !== exp || idx >= n) begin
                    nerr++;
                    $display("FAIL pixel #%0d got %h exp %h", idx, got, exp);
                end
                idx++;
                if (idx == n) last_xfer = cyc;
            end
            stall_prev = pix_valid && !pix_ready;
            held = {pix_sof, pix_eol, pix_eof, pix_data};
            if (ndone == 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        nvec++;
        if (ndone != 1 || idx != n || nrd != n) begin
            nerr++;
            $display("FAIL frame_totals got done=%0d pix=%0d reads=%0d exp 1 %0d %0d", ndone, idx, nrd, n, n);
        end
        if (mode == 0) begin
            nvec++;
            if (last_xfer != n + 2) begin
                nerr++;
                $display("FAIL last_xfer_edge got %0d exp %0d", last_xfer, n + 2);
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            nvec++;
            if ({busy, done, mem_en, pix_valid} !== 4'b0000) begin
                nerr++;
                $display("FAIL idle_after got %b exp 0000", {busy, done, mem_en, pix_valid});
            end
        end
    endtask

    task automatic test_reset();
        #3;
        nvec++;
        if ({mem_en, mem_addr, pix_valid, pix_data, pix_sof, pix_eol, pix_eof, busy, done, err} !== '0) begin
            nerr++;
            $display("FAIL reset_state got en=%b addr=%h v=%b d=%h busy=%b done=%b err=%b exp all 0",
                     mem_en, mem_addr, pix_valid, pix_data, busy, done, err);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_zero_dim();
        int dims[3][2] = '{'{0, 3}, '{0, 5}, '{4, 0}};
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            width = 16'(dims[t][0]); height = 16'(dims[t][1]); base_addr = 20'h00040; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            #1;
            nvec++;
            if ({err, busy, mem_en} !== 3'b100) begin
                nerr++;
                $display("FAIL zero_dim_err w=%0d h=%0d got err,busy,en=%b exp 100", dims[t][0], dims[t][1], {err, busy, mem_en});
            end
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                #1;
                nvec++;
                if ({err, busy, mem_en, pix_valid} !== 4'b0000) begin
                    nerr++;
                    $display("FAIL zero_dim_quiet got %b exp 0000", {err, busy, mem_en, pix_valid});
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int xf = 0, cyc = 0;
        bit saw_done = 0;
        @(negedge clk);
        width = 16'd4; height = 16'd4; base_addr = 20'h2A000; start = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (xf < 4 && cyc < 40) begin
            #1;
            if (done) saw_done = 1;
            if (pix_valid && pix_ready) xf++;
            @(negedge clk);
            cyc++;
        end
        nvec++;
        if (xf != 4 || saw_done) begin
            nerr++;
            $display("FAIL midframe_progress got xfers=%0d done=%b exp 4 0", xf, saw_done);
        end
        #2 rstn = 1'b0;
        #1;
        nvec++;
        if ({mem_en, mem_addr, pix_valid, pix_data, pix_sof, pix_eol, pix_eof, busy, done, err} !== '0) begin
            nerr++;
            $display("FAIL midframe_reset got en=%b addr=%h v=%b d=%h busy=%b done=%b exp all 0",
                     mem_en, mem_addr, pix_valid, pix_data, busy, done);
        end
        @(negedge clk);
        rstn = 1'b1;
        test_frame(4, 4, 20'h2A000, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            test_frame($urandom_range(1, 6), $urandom_range(1, 5), 20'($urandom), 2, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_frame(3, 2, 20'h00100, 0, 1'b0);   // basic raster frame
        test_frame(3, 2, 20'h00100, 1, 1'b0);   // backpressure pattern
        test_frame(1, 1, 20'h00777, 0, 1'b0);   // single pixel
        test_frame(1, 4, 20'h00020, 2, 1'b0);   // one-pixel rows
        test_zero_dim();
        test_frame(4, 3, 20'h05000, 2, 1'b1);   // start mid-frame ignored
        test_reset_midframe();
        test_frame(2, 2, 20'hFFFFE, 0, 1'b0);   // address wrap
        test_frame(2, 2, 20'hFFFFE, 1, 1'b0);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
